// File: rtl/avs_energy_window.sv
// Event-detector front end: squares each AVS sample and keeps short-window (energy)
// and long-window (TH) sums of squares, with a fill/run state tracking long-window fill.
module avs_energy_window #(
    parameter int SAMPLE_W   = 16,
    parameter int SHORT_SIZE = 15,
    parameter int LONG_SIZE  = 31
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sampleValid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       freeze,
    output logic signed [63:0]         energy,
    output logic signed [63:0]         TH,
    output logic                       energyValid,
    output logic                       initDone
);

    localparam int SQ_W  = 2 * SAMPLE_W;
    localparam int SUM_W = SQ_W + $clog2(LONG_SIZE + 1);
    localparam int SP_W  = $clog2(SHORT_SIZE);
    localparam int LP_W  = $clog2(LONG_SIZE);
    localparam int FC_W  = $clog2(LONG_SIZE + 1);

    localparam logic [SP_W-1:0] SPTR_LAST = SP_W'(SHORT_SIZE - 1);
    localparam logic [LP_W-1:0] LPTR_LAST = LP_W'(LONG_SIZE - 1);
    localparam logic [FC_W-1:0] FC_FULL   = FC_W'(LONG_SIZE);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic signed [SQ_W-1:0] prod;

    logic [SQ_W-1:0]  sq_q, sq_d;
    logic             vld1_q, vld1_d;
    logic [SQ_W-1:0]  sbuf_q [SHORT_SIZE];
    logic [SQ_W-1:0]  sbuf_d [SHORT_SIZE];
    logic [SQ_W-1:0]  lbuf_q [LONG_SIZE];
    logic [SQ_W-1:0]  lbuf_d [LONG_SIZE];
    logic [SP_W-1:0]  sptr_q, sptr_d;
    logic [LP_W-1:0]  lptr_q, lptr_d;
    logic [FC_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [SUM_W-1:0] short_sum_q, short_sum_d;
    logic [SUM_W-1:0] long_sum_q, long_sum_d;
    logic [SUM_W-1:0] energy_q, energy_d;
    logic [SUM_W-1:0] th_q, th_d;
    logic             energy_valid_q, energy_valid_d;

    // Signed square of a full-width sample always fits in SQ_W bits as an unsigned value.
    assign prod = sample * sample;

    always_comb begin
        sq_d           = sq_q;
        vld1_d         = sampleValid;
        sbuf_d         = sbuf_q;
        lbuf_d         = lbuf_q;
        sptr_d         = sptr_q;
        lptr_d         = lptr_q;
        fill_cnt_d     = fill_cnt_q;
        short_sum_d    = short_sum_q;
        long_sum_d     = long_sum_q;
        energy_d       = energy_q;
        th_d           = th_q;
        energy_valid_d = 1'b0;

        if (sampleValid) begin
            sq_d = unsigned'(prod);
        end

        if (vld1_q) begin
            short_sum_d    = short_sum_q + SUM_W'(sq_q) - SUM_W'(sbuf_q[sptr_q]);
            sbuf_d[sptr_q] = sq_q;
            sptr_d         = (sptr_q == SPTR_LAST) ? '0 : sptr_q + 1'b1;

            if (!freeze) begin
                long_sum_d     = long_sum_q + SUM_W'(sq_q) - SUM_W'(lbuf_q[lptr_q]);
                lbuf_d[lptr_q] = sq_q;
                lptr_d         = (lptr_q == LPTR_LAST) ? '0 : lptr_q + 1'b1;
                fill_cnt_d     = (fill_cnt_q == FC_FULL) ? fill_cnt_q : fill_cnt_q + 1'b1;
            end

            energy_d       = short_sum_d;
            th_d           = long_sum_d;
            energy_valid_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (fill_cnt_d == FC_FULL) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sq_q           <= '0;
            vld1_q         <= 1'b0;
            sbuf_q         <= '{default: '0};
            lbuf_q         <= '{default: '0};
            sptr_q         <= '0;
            lptr_q         <= '0;
            fill_cnt_q     <= '0;
            short_sum_q    <= '0;
            long_sum_q     <= '0;
            energy_q       <= '0;
            th_q           <= '0;
            energy_valid_q <= 1'b0;
        end else begin
            sq_q           <= sq_d;
            vld1_q         <= vld1_d;
            sbuf_q         <= sbuf_d;
            lbuf_q         <= lbuf_d;
            sptr_q         <= sptr_d;
            lptr_q         <= lptr_d;
            fill_cnt_q     <= fill_cnt_d;
            short_sum_q    <= short_sum_d;
            long_sum_q     <= long_sum_d;
            energy_q       <= energy_d;
            th_q           <= th_d;
            energy_valid_q <= energy_valid_d;
        end
    end

    assign energy      = signed'({{(64 - SUM_W){1'b0}}, energy_q});
    assign TH          = signed'({{(64 - SUM_W){1'b0}}, th_q});
    assign energyValid = energy_valid_q;
    assign initDone    = (state_q == RUN);

endmodule
